snn_output_spike_classifier: RTL and testbench

//  Sits directly downstream of the 1x1 SNN grid, consuming its packet_out/packet_out_valid stream.

---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_class_counter_bank.sv | 60 ++++++
 rtl/snn_output_spike_classifier.sv | 132 +++++++++++++
 tb/tb_snn_output_spike_classifier.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared defaults and state encoding for the SNN output spike classifier.
package snn_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned CLASS_W     = 8;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResult
    } state_e;

endpackage

// File: rtl/snn_class_counter_bank.sv
// Per-class live spike counters with a shadow snapshot and an indexed shadow read port.
module snn_class_counter_bank #(
    parameter int unsigned NumClasses = 10,
    parameter int unsigned ClassW     = 8,
    parameter int unsigned CntW       = 8,
    parameter int unsigned IdxW       = $clog2(NumClasses)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spike_valid,
    input  logic [ClassW-1:0] spike_id,
    input  logic              snapshot,
    input  logic              clear,
    input  logic [IdxW-1:0]   rd_idx,
    output logic [CntW-1:0]   rd_cnt
);

    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

    logic [CntW-1:0]       live_q   [NumClasses];
    logic [CntW-1:0]       shadow_q [NumClasses];
    logic [NumClasses-1:0] inc;

    always_comb begin
        inc = '0;
        for (int i = 0; i < NumClasses; i++) begin
            inc[i] = spike_valid && (spike_id == ClassW'(i));
        end
    end

    // Snapshot folds in a coincident spike; clear wins over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumClasses; i++) begin
                live_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumClasses; i++) begin
                if (snapshot) begin
                    shadow_q[i] <= (inc[i] && live_q[i] != CntMax) ? live_q[i] + 1'b1
                                                                   : live_q[i];
                end
                if (clear) begin
                    live_q[i] <= '0;
                end else if (inc[i] && live_q[i] != CntMax) begin
                    live_q[i] <= live_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        for (int i = 0; i < NumClasses; i++) begin
            if (rd_idx == IdxW'(i)) rd_cnt = shadow_q[i];
        end
    end

endmodule

// File: rtl/snn_output_spike_classifier.sv
// Counts output spikes per class over a frame, scans for the argmax and hands the winner out.
module snn_output_spike_classifier
    import snn_pkg::*;
#(
    parameter int unsigned NumClasses = NUM_CLASSES,
    parameter int unsigned ClassW     = CLASS_W,
    parameter int unsigned CntW       = CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ClassW-1:0] packet_out,
    input  logic              packet_out_valid,
    input  logic              frame_done,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [ClassW-1:0] result_class,
    output logic [CntW-1:0]   result_count,
    output logic              busy,
    output logic              frame_dropped,
    output logic              class_error
);

    localparam int unsigned IdxW = $clog2(NumClasses);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   best_id_q, best_id_d;
    logic [CntW-1:0]   best_cnt_q, best_cnt_d;
    logic              result_valid_q, result_valid_d;
    logic [ClassW-1:0] result_class_q, result_class_d;
    logic [CntW-1:0]   result_count_q, result_count_d;
    logic              frame_dropped_q, class_error_q;

    logic              in_range, spike_ok, snapshot;
    logic [CntW-1:0]   rd_cnt, cand_cnt;
    logic [IdxW-1:0]   cand_id;

    assign in_range = packet_out < ClassW'(NumClasses);
    assign spike_ok = packet_out_valid && in_range;
    assign snapshot = (state_q == StIdle) && frame_done;

    snn_class_counter_bank #(
        .NumClasses (NumClasses),
        .ClassW     (ClassW),
        .CntW       (CntW),
        .IdxW       (IdxW)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .spike_valid (spike_ok),
        .spike_id    (packet_out),
        .snapshot    (snapshot),
        .clear       (frame_done),
        .rd_idx      (idx_q),
        .rd_cnt      (rd_cnt)
    );

    // Strict compare keeps the lowest id on ties.
    assign cand_cnt = (rd_cnt > best_cnt_q) ? rd_cnt : best_cnt_q;
    assign cand_id  = (rd_cnt > best_cnt_q) ? idx_q  : best_id_q;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        best_id_d      = best_id_q;
        best_cnt_d     = best_cnt_q;
        result_valid_d = result_valid_q;
        result_class_d = result_class_q;
        result_count_d = result_count_q;
        unique case (state_q)
            StIdle: begin
                if (frame_done) begin
                    idx_d      = '0;
                    best_id_d  = '0;
                    best_cnt_d = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                best_id_d  = cand_id;
                best_cnt_d = cand_cnt;
                if (idx_q == IdxW'(NumClasses - 1)) begin
                    result_class_d = ClassW'(cand_id);
                    result_count_d = cand_cnt;
                    result_valid_d = 1'b1;
                    state_d        = StResult;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StResult: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            best_id_q       <= '0;
            best_cnt_q      <= '0;
            result_valid_q  <= 1'b0;
            result_class_q  <= '0;
            result_count_q  <= '0;
            frame_dropped_q <= 1'b0;
            class_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            best_id_q       <= best_id_d;
            best_cnt_q      <= best_cnt_d;
            result_valid_q  <= result_valid_d;
            result_class_q  <= result_class_d;
            result_count_q  <= result_count_d;
            frame_dropped_q <= frame_done && (state_q != StIdle);
            class_error_q   <= class_error_q | (packet_out_valid && !in_range);
        end
    end

    assign result_valid  = result_valid_q;
    assign result_class  = result_class_q;
    assign result_count  = result_count_q;
    assign busy          = (state_q != StIdle);
    assign frame_dropped = frame_dropped_q;
    assign class_error   = class_error_q;

endmodule

// File: tb/tb_snn_output_spike_classifier.sv
// Directed bench for snn_output_spike_classifier with immediate-assertion checks.
module tb_snn_output_spike_classifier;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] packet_out;
    logic       packet_out_valid;
    logic       frame_done;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result_class;
    logic [7:0] result_count;
    logic       busy;
    logic       frame_dropped;
    logic       class_error;

    int checks = 0;
    int errors = 0;

    snn_output_spike_classifier dut (
        .clk              (clk),
        .reset            (reset),
        .packet_out       (packet_out),
        .packet_out_valid (packet_out_valid),
        .frame_done       (frame_done),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_class     (result_class),
        .result_count     (result_count),
        .busy             (busy),
        .frame_dropped    (frame_dropped),
        .class_error      (class_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic spikes(input logic [7:0] id, input int n);
        for (int k = 0; k < n; k++) begin
            packet_out       = id;
            packet_out_valid = 1'b1;
            tick();
        end
        packet_out_valid = 1'b0;
    endtask

    task automatic close_frame();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, {31'b0, result_valid}, 32'd1);
    endtask

    task automatic expect_result(input string tag, input int cls, input int cnt);
        wait_result(tag);
        chk({tag, "_class"}, {24'b0, result_class}, cls);
        chk({tag, "_count"}, {24'b0, result_count}, cnt);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'b0, result_valid}, 0);
        chk({tag, "_class"}, {24'b0, result_class}, 0);
        chk({tag, "_count"}, {24'b0, result_count}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_drop"}, {31'b0, frame_dropped}, 0);
        chk({tag, "_cerr"}, {31'b0, class_error}, 0);
    endtask

    initial begin
        reset            = 1'b1;
        packet_out       = '0;
        packet_out_valid = 1'b0;
        frame_done       = 1'b0;
        result_ready     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_outputs("reset");

        // 1: basic frame and exact latency (result_valid in cycle T+11)
        spikes(8'd3, 3);
        spikes(8'd7, 2);
        close_frame();
        chk("t1_busy", {31'b0, busy}, 1);
        for (int k = 0; k < 9; k++) tick();
        chk("t1_early", {31'b0, result_valid}, 0);
        tick();
        chk("t1_latency", {31'b0, result_valid}, 1);
        chk("t1_class", {24'b0, result_class}, 3);
        chk("t1_count", {24'b0, result_count}, 3);
        handshake();
        chk("t1_hs_valid", {31'b0, result_valid}, 0);
        chk("t1_hs_busy", {31'b0, busy}, 0);

        // 2: tie resolves to lowest id; empty frame
        spikes(8'd4, 2);
        spikes(8'd1, 2);
        close_frame();
        expect_result("t2_tie", 1, 2);
        handshake();
        close_frame();
        expect_result("t2_empty", 0, 0);
        handshake();

        // 3: saturation
        spikes(8'd5, 300);
        close_frame();
        expect_result("t3_sat", 5, 255);
        handshake();

        // 4: frame dropped while result pending
        spikes(8'd6, 2);
        close_frame();
        expect_result("t4_first", 6, 2);
        spikes(8'd2, 1);
        close_frame();
        chk("t4_drop_pulse", {31'b0, frame_dropped}, 1);
        tick();
        chk("t4_drop_end", {31'b0, frame_dropped}, 0);
        chk("t4_held_class", {24'b0, result_class}, 6);
        chk("t4_held_count", {24'b0, result_count}, 2);
        spikes(8'd8, 3);
        spikes(8'd9, 1);
        handshake();
        close_frame();
        expect_result("t4_third", 8, 3);
        // frame_done coincident with handshake: dropped, handshake still completes
        result_ready = 1'b1;
        frame_done   = 1'b1;
        tick();
        result_ready = 1'b0;
        frame_done   = 1'b0;
        chk("t4_coinc_drop", {31'b0, frame_dropped}, 1);
        chk("t4_coinc_valid", {31'b0, result_valid}, 0);
        chk("t4_coinc_busy", {31'b0, busy}, 0);

        // 5: out-of-range id and spike coincident with frame_done
        spikes(8'd12, 1);
        chk("t5_cerr", {31'b0, class_error}, 1);
        packet_out       = 8'd2;
        packet_out_valid = 1'b1;
        frame_done       = 1'b1;
        tick();
        packet_out_valid = 1'b0;
        frame_done       = 1'b0;
        expect_result("t5_coinc", 2, 1);
        chk("t5_cerr_sticky", {31'b0, class_error}, 1);
        handshake();
        close_frame();
        expect_result("t5_next", 0, 0);
        handshake();

        // 6: reset during SCAN and during RESULT
        spikes(8'd1, 1);
        close_frame();
        tick();
        spikes(8'd3, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("t6_scan_rst");
        spikes(8'd4, 1);
        close_frame();
        expect_result("t6_after_scan", 4, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_outputs("t6_res_rst");
        spikes(8'd7, 2);
        close_frame();
        expect_result("t6_final", 7, 2);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
